// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encoding, flag bit positions
// and the shift-sequencer state.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP = 4'b0000,
        OP_ADD = 4'b0001,
        OP_SUB = 4'b0010,
        OP_AND = 4'b0011,
        OP_ORR = 4'b0100,
        OP_NOR = 4'b0101,
        OP_XOR = 4'b0110,
        OP_RSH = 4'b0111,
        OP_LSH = 4'b1000,
        OP_LDI = 4'b1001,
        OP_ADI = 4'b1010,
        OP_RSN = 4'b1011,
        OP_LSN = 4'b1100,
        OP_CMP = 4'b1101
    } op_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational datapath for every single-cycle operation. Multi-bit shifts
// report a pass-through of a with C=0, which is the zero-distance result.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic [3:0]       nzcv,
    output logic             upd_o,
    output logic             upd_f
);

    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [WIDTH:0]          sum;
    logic [WIDTH:0]          diff;
    logic                    c;
    logic                    v;

    assign sa   = a;
    assign sb   = b;
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        res   = a;
        c     = 1'b0;
        v     = 1'b0;
        upd_o = 1'b1;
        upd_f = 1'b1;
        case (op)
            OP_ADD, OP_ADI: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (sa[WIDTH-1] == sb[WIDTH-1]) && (sum[WIDTH-1] != sa[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                res   = diff[WIDTH-1:0];
                c     = diff[WIDTH];
                v     = (sa[WIDTH-1] != sb[WIDTH-1]) && (diff[WIDTH-1] != sa[WIDTH-1]);
                upd_o = (op != OP_CMP);
            end
            OP_AND: res = a & b;
            OP_ORR: res = a | b;
            OP_NOR: res = ~(a | b);
            OP_XOR: res = a ^ b;
            OP_LDI: res = b;
            OP_RSH: begin
                res = {1'b0, a[WIDTH-1:1]};
                c   = a[0];
            end
            OP_LSH: begin
                res = {a[WIDTH-2:0], 1'b0};
                c   = a[WIDTH-1];
            end
            OP_RSN, OP_LSN: res = a;
            default: begin
                upd_o = 1'b0;
                upd_f = 1'b0;
            end
        endcase
        nzcv         = 4'b0000;
        nzcv[FLAG_Z] = (res == '0);
        nzcv[FLAG_N] = res[WIDTH-1];
        nzcv[FLAG_C] = c;
        nzcv[FLAG_V] = v;
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: valid/ready handshake around alu_core, with a bit-serial
// sequencer for multi-bit shifts (one bit per cycle, ready low meanwhile).
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int FLAGS_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         opcode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   o,
    output logic [FLAGS_W-1:0] flags,
    output logic               o_valid
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    op_e              op_p0;
    logic [WIDTH-1:0] res_p0;
    logic [3:0]       nzcv_p0;
    logic             upd_o_p0;
    logic             upd_f_p0;
    logic             multi_p0;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sh_data;
    logic             sh_left;
    logic [WIDTH-1:0] sh_next;
    logic             sh_out;

    // Distances beyond the operand width all give the same all-zero result.
    function automatic logic [CNT_W-1:0] clamp_dist(input logic [WIDTH-1:0] d);
        if (32'(d) >= 32'(WIDTH)) return CNT_W'(WIDTH);
        return CNT_W'(d);
    endfunction

    function automatic logic [FLAGS_W-1:0] pack_flags(input logic [WIDTH-1:0] r, input logic c);
        logic [FLAGS_W-1:0] f;
        f         = '0;
        f[FLAG_Z] = (r == '0);
        f[FLAG_N] = r[WIDTH-1];
        f[FLAG_C] = c;
        return f;
    endfunction

    assign op_p0    = op_e'(opcode);
    assign multi_p0 = ((op_p0 == OP_RSN) || (op_p0 == OP_LSN)) && (b != '0);
    assign in_ready = (state == ST_IDLE) && !rst;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op    (op_p0),
        .a     (a),
        .b     (b),
        .res   (res_p0),
        .nzcv  (nzcv_p0),
        .upd_o (upd_o_p0),
        .upd_f (upd_f_p0)
    );

    assign sh_next = sh_left ? {sh_data[WIDTH-2:0], 1'b0} : {1'b0, sh_data[WIDTH-1:1]};
    assign sh_out  = sh_left ? sh_data[WIDTH-1] : sh_data[0];

    // p0 -> registered outputs: single-cycle results land at the accept edge,
    // serial shifts land on the edge that moves the final bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            sh_data <= '0;
            sh_left <= 1'b0;
            o       <= '0;
            flags   <= '0;
            o_valid <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (multi_p0) begin
                            state   <= ST_SHIFT;
                            cnt     <= clamp_dist(b);
                            sh_data <= a;
                            sh_left <= (op_p0 == OP_LSN);
                        end else begin
                            if (upd_o_p0) o <= res_p0;
                            if (upd_f_p0) flags <= FLAGS_W'(nzcv_p0);
                            o_valid <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    sh_data <= sh_next;
                    cnt     <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        state   <= ST_IDLE;
                        o       <= sh_next;
                        flags   <= pack_flags(sh_next, sh_out);
                        o_valid <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=4): the driver queues expected results
// with their completion cycle, a negedge monitor checks each o_valid pulse.
module tb_alu_seq;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   opcode = 4'h0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W-1:0] o;
    logic [7:0]   flags;
    logic         o_valid;

    typedef struct {
        logic [W-1:0] o;
        logic [7:0]   f;
        int           cyc;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   ntests = 0;
    int   nfail = 0;

    alu_seq #(.WIDTH(W), .FLAGS_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .opcode   (opcode),
        .a        (a),
        .b        (b),
        .o        (o),
        .flags    (flags),
        .o_valid  (o_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every o_valid pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (o_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_o_valid", 32'(o), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_o"}, 32'(o), 32'(e.o));
                chk({e.name, "_flags"}, 32'(flags), 32'(e.f));
                chk({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Issue one single-cycle op; in_valid is left high so calls run back-to-back.
    task automatic send(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] eo, input logic [7:0] ef, input string name);
        in_valid = 1'b1;
        opcode   = op;
        a        = va;
        b        = vb;
        @(posedge clk);
        #1;
        sb.push_back('{o: eo, f: ef, cyc: cyc, name: name});
    endtask

    // Serial shift: ready must stay low for iters cycles while a competing
    // request is held on the inputs, then return high.
    task automatic shift_op(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                            input int iters, input logic [W-1:0] eo, input logic [7:0] ef,
                            input string name);
        in_valid = 1'b1;
        opcode   = op;
        a        = va;
        b        = vb;
        @(posedge clk);
        #1;
        sb.push_back('{o: eo, f: ef, cyc: cyc + iters, name: name});
        opcode = 4'h1;
        a      = 4'h1;
        b      = 4'h1;
        for (int i = 0; i < iters; i++) begin
            chk({name, "_busy"}, 32'(in_ready), 32'd0);
            if (i == iters - 1) in_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        chk({name, "_ready_after"}, 32'(in_ready), 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #2;
        chk("reset_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #2;
        chk("reset_o", 32'(o), 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        chk("reset_o_valid", 32'(o_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        // Back-to-back single-cycle ops, one per clock.
        send(4'h1, 4'b0111, 4'b1001, 4'b0000, 8'h03, "add_carry");
        send(4'h1, 4'b0111, 4'b0001, 4'b1000, 8'h0C, "add_ovf");
        send(4'h2, 4'b0011, 4'b0101, 4'b1110, 8'h06, "sub_borrow");
        send(4'hD, 4'b0101, 4'b0101, 4'b1110, 8'h01, "cmp_eq");
        send(4'h0, 4'b1111, 4'b1111, 4'b1110, 8'h01, "nop0");
        send(4'hE, 4'b0001, 4'b0001, 4'b1110, 8'h01, "nop14");
        send(4'h3, 4'b1100, 4'b1010, 4'b1000, 8'h04, "and");
        send(4'h4, 4'b0000, 4'b0000, 4'b0000, 8'h01, "orr_zero");
        send(4'h5, 4'b0101, 4'b1010, 4'b0000, 8'h01, "nor");
        send(4'h6, 4'b1100, 4'b1010, 4'b0110, 8'h00, "xor");
        send(4'h7, 4'b0011, 4'b0000, 4'b0001, 8'h02, "rsh");
        send(4'h8, 4'b1001, 4'b0000, 4'b0010, 8'h02, "lsh");
        send(4'h9, 4'b0000, 4'b1011, 4'b1011, 8'h04, "ldi");
        send(4'hA, 4'b1000, 4'b1000, 4'b0000, 8'h0B, "adi_ovf");
        send(4'h2, 4'b1000, 4'b0001, 4'b0111, 8'h08, "sub_ovf");
        idle(2);

        shift_op(4'hC, 4'b0011, 4'd3, 3, 4'b1000, 8'h06, "lsn3");
        idle(1);
        shift_op(4'hB, 4'b1101, 4'd15, 4, 4'b0000, 8'h03, "rsn_clamp");
        idle(1);
        shift_op(4'hC, 4'b0001, 4'd2, 2, 4'b0100, 8'h00, "lsn2");
        idle(1);
        shift_op(4'hB, 4'b1000, 4'd1, 1, 4'b0100, 8'h00, "rsn1");
        send(4'hB, 4'b1011, 4'd0, 4'b1011, 8'h04, "rsn0");
        idle(2);

        // Reset in the second SHIFT cycle aborts the shift silently.
        in_valid = 1'b1;
        opcode   = 4'hC;
        a        = 4'b0011;
        b        = 4'd3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_o", 32'(o), 32'd0);
        chk("abort_flags", 32'(flags), 32'd0);
        chk("abort_ready_in_rst", 32'(in_ready), 32'd0);
        #3;
        rst = 1'b0;
        #1;
        chk("abort_ready_after", 32'(in_ready), 32'd1);
        idle(5);

        send(4'h1, 4'b0010, 4'b0011, 4'b0101, 8'h00, "add_after_abort");
        idle(8);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
